// File: rtl/rst_seq.sv
// Lock-qualified reset sequencer: holds reset until lock has been stable, then releases CHANNELS resets in index order.
// Optional saturating lock-loss counter built only when RST_SEQ_RELOCK_COUNT_EN is defined.
module rst_seq #(
    parameter int CHANNELS    = 3,
    parameter int SYNC_STAGES = 4,
    parameter int HOLD_CYCLES = 1250,
    parameter int STAGE_DELAY = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                lock,
    input  logic                soft_reset,
    output logic [CHANNELS-1:0] rst_out,
    output logic                ready,
    output logic [7:0]          relock_count
);

    localparam int CNT_MAX = (HOLD_CYCLES > STAGE_DELAY) ? HOLD_CYCLES : STAGE_DELAY;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int K_W     = $clog2(CHANNELS + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(STAGE_DELAY - 1);
    localparam logic [K_W-1:0]   K_LAST     = K_W'(CHANNELS - 1);

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_RELEASE = 2'd1,
        S_RUN     = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_sync;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [K_W-1:0]         k_q, k_d;
    logic [CHANNELS-1:0]    rst_q, rst_d;
    logic                   ready_q, ready_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], lock};
        end
    end

    assign lock_sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_HOLD;
            cnt_q   <= '0;
            k_q     <= '0;
            rst_q   <= '1;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            rst_q   <= rst_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        rst_d   = rst_q;
        ready_d = ready_q;
        case (state_q)
            S_HOLD: begin
                if (lock_sync && !soft_reset) begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = S_RELEASE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            S_RELEASE, S_RUN: begin
                // Abort is evaluated first so it overrides a release due on the same edge.
                if (!lock_sync || soft_reset) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                    k_d     = '0;
                    rst_d   = '1;
                    ready_d = 1'b0;
                end else if (state_q == S_RELEASE) begin
                    if (cnt_q == DELAY_LAST) begin
                        cnt_d = '0;
                        k_d   = k_q + K_W'(1);
                        rst_d = rst_q & ~(CHANNELS'(1) << k_q);
                        if (k_q == K_LAST) begin
                            state_d = S_RUN;
                            ready_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_HOLD;
                cnt_d   = '0;
                k_d     = '0;
                rst_d   = '1;
                ready_d = 1'b0;
            end
        endcase
    end

    assign rst_out = rst_q;
    assign ready   = ready_q;

`ifdef RST_SEQ_RELOCK_COUNT_EN
    logic [7:0] relock_q, relock_d;
    logic       relock_inc;

    // Only lock loss while sequencing or running counts; soft aborts are ignored.
    assign relock_inc = (state_q != S_HOLD) && !lock_sync;

    always_comb begin
        relock_d = relock_q;
        if (relock_inc && (relock_q != 8'hFF)) begin
            relock_d = relock_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            relock_q <= 8'd0;
        end else begin
            relock_q <= relock_d;
        end
    end

    assign relock_count = relock_q;
`else
    assign relock_count = 8'd0;
`endif

endmodule

// File: tb/tb_rst_seq.sv
// Self-checking bench for rst_seq: directed scenarios plus random lock/soft_reset traffic
// compared against a streak-based reference model.
module tb_rst_seq;

    localparam int C = 3;
    localparam int S = 2;
    localparam int H = 8;
    localparam int D = 4;
    localparam int CAP = H + C * D;

    logic         clk;
    logic         reset;
    logic         lock;
    logic         soft_reset;
    logic [C-1:0] rst_out;
    logic         ready;
    logic [7:0]   relock_count;

    int errors = 0;
    int checks = 0;
    int e = 0;

    // Reference model: outputs depend only on how many consecutive qualifying edges
    // (synchronised lock high, no soft request) have occurred.
    bit hist [S];
    int m_streak;
    int m_relock;

    rst_seq #(
        .CHANNELS   (C),
        .SYNC_STAGES(S),
        .HOLD_CYCLES(H),
        .STAGE_DELAY(D)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .lock        (lock),
        .soft_reset  (soft_reset),
        .rst_out     (rst_out),
        .ready       (ready),
        .relock_count(relock_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        bit ls;
        if (reset) begin
            m_streak = 0;
            m_relock = 0;
            for (int i = 0; i < S; i++) hist[i] = 1'b0;
        end else begin
            ls = hist[S-1];
            for (int i = S - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = lock;
            if (ls && !soft_reset) begin
                m_streak = (m_streak + 1 > CAP) ? CAP : m_streak + 1;
            end else begin
                if (!ls && m_streak >= H && m_relock < 255) m_relock = m_relock + 1;
                m_streak = 0;
            end
        end
    end

    function automatic logic [C-1:0] exp_rst(input int streak);
        int n;
        logic [C-1:0] r;
        n = (streak < H) ? 0 : (streak - H) / D;
        if (n > C) n = C;
        r = '1;
        for (int i = 0; i < C; i++) if (i < n) r[i] = 1'b0;
        return r;
    endfunction

    function automatic logic [7:0] exp_relock();
`ifdef RST_SEQ_RELOCK_COUNT_EN
        return 8'(m_relock);
`else
        return 8'd0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s (edge %0d): got %0h expected %0h", tag, e, obs, exp);
        end
    endtask

    task automatic tick(input logic l, input logic s);
        lock       = l;
        soft_reset = s;
        @(posedge clk);
        #1;
        e++;
        chk("rst_out", 32'(rst_out), 32'(exp_rst(m_streak)));
        chk("ready", 32'(ready), 32'(m_streak >= CAP));
        chk("relock_count", 32'(relock_count), 32'(exp_relock()));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        e = 0;
    endtask

    initial begin
        bit done;
        int len;
        logic l;
        logic s;

        reset      = 1'b1;
        lock       = 1'b1;
        soft_reset = 1'b0;
        #12;
        chk("reset_rst_out", 32'(rst_out), 32'h7);
        chk("reset_ready", 32'(ready), 32'h0);
        chk("reset_relock", 32'(relock_count), 32'h0);

        // Power-up schedule
        do_reset();
        for (int i = 1; i <= 13; i++) tick(1'b1, 1'b0);
        chk("pu_e13", 32'(rst_out), 32'h7);
        tick(1'b1, 1'b0);
        chk("pu_e14", 32'(rst_out), 32'h6);
        for (int i = 15; i <= 18; i++) tick(1'b1, 1'b0);
        chk("pu_e18", 32'(rst_out), 32'h4);
        for (int i = 19; i <= 21; i++) tick(1'b1, 1'b0);
        chk("pu_e21_ready", 32'(ready), 32'h0);
        tick(1'b1, 1'b0);
        chk("pu_e22", 32'(rst_out), 32'h0);
        chk("pu_e22_ready", 32'(ready), 32'h1);

        // Lock loss in RUN, then full re-sequence
        for (int i = 23; i <= 25; i++) tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        chk("loss_e27_still_run", 32'(rst_out), 32'h0);
        tick(1'b1, 1'b0);
        chk("loss_e28_rst", 32'(rst_out), 32'h7);
        chk("loss_e28_ready", 32'(ready), 32'h0);
`ifdef RST_SEQ_RELOCK_COUNT_EN
        chk("loss_relock", 32'(relock_count), 32'h1);
`else
        chk("loss_relock", 32'(relock_count), 32'h0);
`endif
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            tick(1'b1, 1'b0);
            done = ready;
        end
        chk("resequence_edge", 32'(e), 32'd48);

        // Lock glitch in HOLD at cnt=5
        do_reset();
        for (int i = 1; i <= 7; i++) tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 9; i <= 14; i++) tick(1'b1, 1'b0);
        chk("glitch_no_early_release", 32'(rst_out), 32'h7);
        for (int i = 15; i <= 21; i++) tick(1'b1, 1'b0);
        chk("glitch_e21", 32'(rst_out), 32'h7);
        tick(1'b1, 1'b0);
        chk("glitch_e22", 32'(rst_out), 32'h6);

        // soft_reset on the edge that would release channel 1
        do_reset();
        for (int i = 1; i <= 17; i++) tick(1'b1, 1'b0);
        chk("soft_e17", 32'(rst_out), 32'h6);
        tick(1'b1, 1'b1);
        chk("soft_abort_wins", 32'(rst_out), 32'h7);
        chk("soft_relock", 32'(relock_count), 32'h0);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);

        // Asynchronous reset between edges mid-RELEASE
        do_reset();
        for (int i = 1; i <= 16; i++) tick(1'b1, 1'b0);
        chk("async_pre", 32'(rst_out), 32'h6);
        #3;
        reset = 1'b1;
        #1;
        chk("async_rst_out", 32'(rst_out), 32'h7);
        chk("async_ready", 32'(ready), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        e = 0;

        // 300 lock losses while sequencing
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < S + H + 2; i++) tick(1'b1, 1'b0);
            for (int i = 0; i < S + 1; i++) tick(1'b0, 1'b0);
        end
`ifdef RST_SEQ_RELOCK_COUNT_EN
        chk("relock_saturate", 32'(relock_count), 32'd255);
`else
        chk("relock_saturate", 32'(relock_count), 32'd0);
`endif

        // Random lock/soft_reset traffic
        do_reset();
        for (int seg = 0; seg < 150; seg++) begin
            len = $urandom_range(1, 30);
            l   = ($urandom_range(0, 9) != 0);
            s   = ($urandom_range(0, 14) == 0);
            for (int i = 0; i < len; i++) tick(l, s && (i == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rst_seq.md
# rst_seq

Parametrised reset sequencer that generalises the single-channel synchronous reset used at the top level. It waits for the clock source to report lock and holds reset for a minimum time. It then releases `CHANNELS` reset outputs one after another, in order, with a fixed gap between each. It sits between the MMCM and the downstream domains (PHY reset, MAC/UDP stack, AXI-Lite RAM), re-sequences on lock loss or a software request, and reports status.

## Interface
- `CHANNELS`, 3: number of sequenced reset outputs; index 0 releases first. Range ≥1.
- `SYNC_STAGES`, 4: synchroniser depth for the asynchronous `lock` input. Range ≥2.
- `HOLD_CYCLES`, 1250: minimum number of cycles `lock_sync` must stay high before sequencing starts (10 µs at 125 MHz). Range ≥1.
- `STAGE_DELAY`, 16: cycles between consecutive channel releases. Range ≥1.

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: asynchronous, active-high. Forces every register to its reset value.
- `lock`, in, 1: clock-source lock. Asynchronous to `clk`; synchronised internally.
- `soft_reset`, in, 1: synchronous request, sampled each cycle. Restarts the sequence.
- `rst_out`, out, CHANNELS: active-high resets. Reset value is all ones.
- `ready`, out, 1: high only in RUN. Reset value 0.
- `relock_count`, out, 8: saturating count of lock-loss events. Reset value 0.

## Operation
- `lock` passes through a `SYNC_STAGES` flop chain, all stages resetting to 0, to produce `lock_sync`.
- A shared counter `cnt` is sized as $clog2(max(HOLD_CYCLES, STAGE_DELAY)+1). A channel index `k` is sized as $clog2(CHANNELS+1).
- State machine: HOLD → RELEASE → RUN. The reset state is HOLD, with `cnt`=0, `k`=0, `rst_out`=all ones and `ready`=0.
- HOLD:
  - `cnt` increments while `lock_sync`=1 and `soft_reset`=0; otherwise `cnt` clears to 0.
  - When `cnt`==HOLD_CYCLES-1 and `lock_sync`=1: go to RELEASE and clear `cnt`.
- RELEASE:
  - `cnt` increments every cycle.
  - When `cnt`==STAGE_DELAY-1: deassert `rst_out[k]`, increment `k` and clear `cnt`.
  - On the edge that deasserts `rst_out[CHANNELS-1]`: go to RUN and set `ready`=1 on the same edge.
- RUN: all outputs are held. `rst_out`=0 and `ready`=1.
- Abort, in RELEASE or RUN, when `lock_sync`=0 or `soft_reset`=1:
  - On the next edge: `rst_out`=all ones, `ready`=0, `cnt`=0, `k`=0, state HOLD.
  - Abort takes priority over any release scheduled for the same edge.
- Released channels stay deasserted while later channels are released. Outputs never deassert out of index order.
- `soft_reset` held high keeps the block in HOLD with `cnt`=0.
- `relock_count`:
  - Increments when an abort is caused by `lock_sync`=0 while in RELEASE or RUN. `soft_reset` aborts do not count.
  - Saturates at 255.
  - Cleared only by `reset`.
  - See Configuration.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Take `lock` steady high and `soft_reset` low. Edge 1 is the first rising edge after `reset` falls. Then:
  - `rst_out[0]` deasserts at edge SYNC_STAGES+HOLD_CYCLES+STAGE_DELAY.
  - `rst_out[k]` deasserts STAGE_DELAY·k edges after `rst_out[0]`.
  - `ready` rises on the same edge as `rst_out[CHANNELS-1]`.
- Abort latency:
  - From a `lock` fall to `rst_out` reasserting: SYNC_STAGES+1 edges.
  - From `soft_reset` sampled high: 1 edge.
- Asserting `reset` mid-operation sets `rst_out` to all ones and `ready` to 0 immediately (asynchronously), without waiting for a clock edge.
- The minimum low time of any `rst_out` bit is never guaranteed. The minimum high time before the first release after any abort is HOLD_CYCLES+STAGE_DELAY cycles.

## Configuration
- `RST_SEQ_RELOCK_COUNT_EN`:
  - Defined: the saturating `relock_count` register is built as described in Operation.
  - Undefined: the register is not built and `relock_count` is tied to 8'd0. The port stays present so the interface is stable.

## Test plan
All scenarios use CHANNELS=3, SYNC_STAGES=2, HOLD_CYCLES=8, STAGE_DELAY=4, with `lock`=1.
- Power-up: release `reset` with `lock`=1 → `rst_out` goes 3'b111→3'b110 at edge 14, →3'b100 at 18, →3'b000 at 22; `ready` rises at 22.
- Lock glitch in HOLD: drop `lock` for 1 cycle when `cnt`=5 → `cnt` restarts and the release schedule shifts later by the full HOLD time; no early release.
- Lock loss in RUN: drop `lock` → `rst_out`=3'b111 and `ready`=0 three edges later; `relock_count`=1 with the macro defined, 0 with it undefined; re-raise `lock` → the full 20-edge sequence repeats.
- `soft_reset` pulse in RELEASE, on the edge where `rst_out[1]` would deassert → `rst_out`=3'b111 (the abort wins); `relock_count` unchanged.
- Async `reset` asserted mid-RELEASE, between edges → `rst_out`=3'b111 and `ready`=0 before the next edge; 300 lock losses → `relock_count` saturates at 255.
